// File: rtl/approx_prod_accum_if.sv
// Handshake bundle between the approximate-product stream, the accumulator and the result consumer.
// The accumulator takes the slave view; the driver and consumer side takes the master view.
interface approx_prod_accum_if #(
  parameter int PW    = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [PW-1:0]    in_prod;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_sat;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat
  );
endinterface

// File: rtl/approx_prod_accum.sv
// Saturating accumulator for a stream of unsigned approximate products; one vector per result.
// state | meaning
// IDLE  | nothing accumulated, waiting for the first beat of a vector
// ACCUM | vector in progress, accepting one beat per cycle
// HOLD  | result presented, input stalled until the consumer takes it
module approx_prod_accum #(
  parameter int PW    = 8,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  approx_prod_accum_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_beat;
  logic [ACC_W:0]   w_prod_ext;
  logic [ACC_W:0]   w_sum;
  logic             w_ovf;
  logic [ACC_W-1:0] w_acc_next;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_beat     = bus.in_valid && r_in_ready;
  assign w_prod_ext = {{(ACC_W + 1 - PW){1'b0}}, bus.in_prod};
  assign w_sum      = {1'b0, r_acc} + w_prod_ext;
  assign w_ovf      = w_sum[ACC_W];
  // A saturated accumulator stays at all-ones: any further non-zero add overflows again.
  assign w_acc_next = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_cnt_next = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) begin
            r_acc <= w_prod_ext[ACC_W-1:0];
            r_cnt <= CNT_W'(1);
            r_sat <= 1'b0;
            if (bus.in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (w_beat) begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_sat <= r_sat | w_ovf;
            if (bus.in_last) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sum   = r_acc;
  assign bus.out_count = r_cnt;
  assign bus.out_sat   = r_sat;

endmodule

// File: tb/tb_approx_prod_accum.sv
// Directed bench for approx_prod_accum built with a 10-bit accumulator so saturation is reachable.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_approx_prod_accum;
  localparam int PW    = 8;
  localparam int ACC_W = 10;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  approx_prod_accum_if #(.PW(PW), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  approx_prod_accum #(.PW(PW), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic v, input int sum, input int cnt,
                         input logic sat, input logic rdy);
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    if (v) begin
      chk({tag, ".out_sum"},   32'(bus.out_sum),   32'(sum));
      chk({tag, ".out_count"}, 32'(bus.out_count), 32'(cnt));
      chk({tag, ".out_sat"},   32'(bus.out_sat),   32'(sat));
    end
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'(rdy));
  endtask

  task automatic beat(input int prod, input logic last);
    bus.in_valid = 1'b1;
    bus.in_prod  = PW'(prod);
    bus.in_last  = last;
    chk("beat.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_prod   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();

    // reset state
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst.out_count", 32'(bus.out_count), 32'd0);
    chk("rst.out_sat",   32'(bus.out_sat),   32'd0);
    chk("rst.in_ready",  32'(bus.in_ready),  32'd1);

    // single-beat vector
    beat(225, 1'b1);
    chk_out("single", 1'b1, 225, 1, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk_out("single.done", 1'b0, 0, 0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;

    // back-to-back vector, then backpressure with upstream holding a beat
    beat(12, 1'b0);
    beat(30, 1'b0);
    beat(0, 1'b0);
    beat(225, 1'b1);
    chk_out("b2b", 1'b1, 267, 4, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_prod  = 8'd99;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("bp.hold", 1'b1, 267, 4, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    chk_out("bp.release", 1'b0, 0, 0, 1'b0, 1'b1);
    step();
    chk_out("bp.idle", 1'b0, 0, 0, 1'b0, 1'b1);
    bus.out_ready = 1'b0;

    // saturation: 5 x 225 = 1125 clips to 1023
    for (int i = 0; i < 4; i++) begin
      beat(225, 1'b0);
      chk("sat.acc.out_valid", 32'(bus.out_valid), 32'd0);
    end
    beat(225, 1'b1);
    chk_out("sat", 1'b1, 1023, 5, 1'b1, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    beat(7, 1'b1);
    chk_out("sat.next", 1'b1, 7, 1, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // reset mid-vector, then reset while holding a result
    beat(100, 1'b0);
    beat(100, 1'b0);
    beat(100, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.out_sum",   32'(bus.out_sum),   32'd0);
    chk("midrst.out_count", 32'(bus.out_count), 32'd0);
    chk("midrst.out_sat",   32'(bus.out_sat),   32'd0);
    chk("midrst.in_ready",  32'(bus.in_ready),  32'd1);
    beat(50, 1'b0);
    beat(50, 1'b1);
    chk_out("after_rst", 1'b1, 100, 2, 1'b0, 1'b0);
    step();
    chk_out("after_rst.hold", 1'b1, 100, 2, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("holdrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("holdrst.out_sum",   32'(bus.out_sum),   32'd0);
    chk("holdrst.in_ready",  32'(bus.in_ready),  32'd1);

    // bubbles: idle cycles with garbage data and last must not count or add
    beat(10, 1'b0);
    bus.in_prod = 8'd77;
    bus.in_last = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("bubble.gap", 1'b0, 0, 0, 1'b0, 1'b1);
    end
    beat(20, 1'b1);
    chk_out("bubble", 1'b1, 30, 2, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // beat counter stops at 255 without raising the sat flag
    for (int i = 0; i < 259; i++) begin
      bus.in_valid = 1'b1;
      bus.in_prod  = 8'd1;
      bus.in_last  = 1'b0;
      step();
    end
    beat(1, 1'b1);
    chk_out("cntsat", 1'b1, 260, 255, 1'b0, 1'b0);
    bus.out_ready = 1'b1;
    step();
    chk_out("cntsat.done", 1'b0, 0, 0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
